imem_uart_loader: RTL and testbench

Serial program loader that writes the instruction memory the core fetches from. It receives a framed byte stream on a UART line (8N1, LSB first), assembles little-endian 32-bit words, and issues single-cycle word writes to the instruction memory write port. The core is held in reset for the whole load and released only after a complete, error-free image. It sits beside the processor top, between the board UART pin and the instruction memory.

---
 rtl/imem_uart_loader_pkg.sv | 28 ++
 rtl/imem_uart_loader_if.sv | 10 +
 rtl/imem_uart_loader_uart_rx_byte.sv | 96 +++++++++
 rtl/imem_uart_loader.sv | 189 ++++++++++++++++++
 tb/tb_imem_uart_loader.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_uart_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
// The optional checksum feature is enabled by IMEM_LOADER_CHECKSUM_EN.
package imem_uart_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERROR
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam int HDR_BYTES = 2;

  function automatic int sample_point(input int cpb);
    return cpb / 2;
  endfunction

endpackage

// File: rtl/imem_uart_loader_if.sv
// Instruction memory word write port driven by the loader.
// Byte address and data are valid while we is high.
interface imem_uart_loader_if;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;

  modport master (output we, output waddr, output wdata);
  modport slave  (input  we, input  waddr, input  wdata);
endinterface

// File: rtl/imem_uart_loader_uart_rx_byte.sv
// 8N1 UART byte receiver: synchroniser, bit timer, shift register.
// valid_o / stop_err_o pulse the cycle after the stop-bit sample.
module uart_rx_byte
  import imem_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       stop_err_o
);

  localparam int HALF = sample_point(CLKS_PER_BIT);
  localparam int CW   = $clog2(CLKS_PER_BIT);

  logic [1:0]    sync_q;
  logic          prev_q;
  rx_state_e     st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;
  logic          rx;

  assign rx         = sync_q[1];
  assign byte_o     = sh_q;
  assign valid_o    = vld_q;
  assign stop_err_o = err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
      st_q   <= RX_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      prev_q <= rx;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q + CW'(1);
    bit_d = bit_q;
    sh_d  = sh_q;
    vld_d = 1'b0;
    err_d = 1'b0;
    unique case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !rx) st_d = RX_START;
      end
      RX_START: begin
        // start bit re-checked mid-bit; a high line means a glitch
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = rx ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          sh_d  = {rx, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          st_d  = RX_IDLE;
          vld_d = rx;
          err_d = !rx;
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/imem_uart_loader.sv
// UART program loader writing instruction memory; holds core in reset.
// Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic clk,
  input  logic resetn,
  input  logic uart_rx,
  input  logic load_start,
  imem_uart_loader_if.master imem,
  output logic core_resetn,
  output logic loading,
  output logic done,
  output logic frame_err
`ifdef IMEM_LOADER_CHECKSUM_EN
  , output logic chk_err
`endif
);

  localparam logic [16:0] MAXW = 17'(1) << ADDR_WIDTH;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam ld_state_e S_TAIL = S_CHK;
`else
  localparam ld_state_e S_TAIL = S_DONE;
`endif

  logic [7:0]  rx_byte;
  logic        rx_vld, rx_serr;
  ld_state_e   st_q, st_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] n;
  logic [1:0]  bidx_q, bidx_d;
  logic [31:0] word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        we_q, we_d;
  logic        ferr_q, ferr_d;
  logic        load_q, done_q, core_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  chk_q, chk_d;
  logic        cerr_q, cerr_d;
  assign chk_err = cerr_q;
`endif

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i      (clk),
    .rst_ni     (resetn),
    .rx_i       (uart_rx),
    .byte_o     (rx_byte),
    .valid_o    (rx_vld),
    .stop_err_o (rx_serr)
  );

  assign imem.we     = we_q;
  assign imem.waddr  = addr_q;
  assign imem.wdata  = data_q;
  assign core_resetn = core_q;
  assign loading     = load_q;
  assign done        = done_q;
  assign frame_err   = ferr_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      st_q   <= S_IDLE;
      len_q  <= '0;
      cnt_q  <= '0;
      bidx_q <= '0;
      word_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
      ferr_q <= 1'b0;
      load_q <= 1'b0;
      done_q <= 1'b0;
      core_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q  <= '0;
      cerr_q <= 1'b0;
`endif
    end else begin
      st_q   <= st_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      bidx_q <= bidx_d;
      word_q <= word_d;
      addr_q <= addr_d;
      data_q <= data_d;
      we_q   <= we_d;
      ferr_q <= ferr_d;
      load_q <= st_d inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHK};
      done_q <= st_d == S_DONE;
      core_q <= st_d inside {S_IDLE, S_DONE};
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q  <= chk_d;
      cerr_q <= cerr_d;
`endif
    end
  end

  always_comb begin
    st_d   = st_q;
    len_d  = len_q;
    cnt_d  = cnt_q;
    bidx_d = bidx_q;
    word_d = word_q;
    addr_d = addr_q;
    data_d = data_q;
    we_d   = 1'b0;
    ferr_d = ferr_q;
    n      = {rx_byte, len_q[7:0]};
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_d  = chk_q;
    cerr_d = cerr_q;
`endif
    unique case (st_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (load_start) begin
          st_d   = S_LEN_LO;
          ferr_d = 1'b0;
          bidx_d = '0;
          cnt_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d  = '0;
          cerr_d = 1'b0;
`endif
        end
      end
      S_LEN_LO: begin
        if (rx_vld) begin
          len_d[7:0] = rx_byte;
          st_d       = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (rx_vld) begin
          len_d[15:8] = rx_byte;
          addr_d      = '0;
          if (n == 16'd0) begin
            st_d = S_TAIL;
          end else if ({1'b0, n} > MAXW) begin
            st_d   = S_ERROR;
            ferr_d = 1'b1;
          end else begin
            st_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        // address advances after the write cycle so it is stable during we
        if (we_q) begin
          addr_d = addr_q + 32'd4;
          if (cnt_q == len_q) st_d = S_TAIL;
        end else if (rx_vld) begin
          word_d = {rx_byte, word_q[31:8]};
          bidx_d = bidx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d  = chk_q ^ rx_byte;
`endif
          if (bidx_q == 2'd3) begin
            we_d   = 1'b1;
            data_d = {rx_byte, word_q[31:8]};
            cnt_d  = cnt_q + 16'd1;
          end
        end
      end
      S_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (rx_vld) begin
          st_d   = (rx_byte == chk_q) ? S_DONE : S_ERROR;
          cerr_d = rx_byte != chk_q;
        end
`else
        st_d = S_ERROR;
`endif
      end
      default: st_d = S_IDLE;
    endcase
    if (rx_serr && (st_q inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHK})) begin
      st_d   = S_ERROR;
      ferr_d = 1'b1;
      we_d   = 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed self-checking bench for imem_uart_loader.
// Build with IMEM_LOADER_CHECKSUM_EN to also exercise the checksum byte.
module tb_imem_uart_loader;

  localparam int CPB = 8;
  localparam int AW  = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic uart_rx = 1'b1;
  logic load_start = 1'b0;
  logic core_resetn, loading, done, frame_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic chk_err;
`endif

  imem_uart_loader_if imem_bus ();

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .uart_rx     (uart_rx),
    .load_start  (load_start),
    .imem        (imem_bus),
    .core_resetn (core_resetn),
    .loading     (loading),
    .done        (done),
    .frame_err   (frame_err)
`ifdef IMEM_LOADER_CHECKSUM_EN
    , .chk_err   (chk_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wn = 0;
  int last_we = 0;
  int done_rise = 0;
  int w0;
  logic done_p = 1'b0;
  logic [31:0] wa [64];
  logic [31:0] wd [64];
  logic [7:0]  bb [80];
  logic [7:0]  tx_x;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    done_p <= done;
    if (done && !done_p) done_rise <= cyc;
    if (imem_bus.we) begin
      if (wn < 64) begin
        wa[wn] <= imem_bus.waddr;
        wd[wn] <= imem_bus.wdata;
      end
      wn <= wn + 1;
      last_we <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_buf(input int n);
    tx_x = 8'h00;
    for (int i = 0; i < n; i++) begin
      send_byte(bb[i], 1'b1);
      if (i >= 2) tx_x = tx_x ^ bb[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(tx_x, 1'b1);
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 4000 && loading; i++) @(negedge clk);
    check(tag, 32'(loading), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check("rst_we", 32'(imem_bus.we), 32'd0);
    check("rst_waddr", imem_bus.waddr, 32'd0);
    check("rst_wdata", imem_bus.wdata, 32'd0);
    check("rst_core", 32'(core_resetn), 32'd0);
    check("rst_loading", 32'(loading), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("core_up", 32'(core_resetn), 32'd1);
    check("idle_load", 32'(loading), 32'd0);

    // two-word image
    pulse_start();
    check("arm_loading", 32'(loading), 32'd1);
    check("arm_core", 32'(core_resetn), 32'd0);
    bb[0] = 8'h02; bb[1] = 8'h00;
    bb[2] = 8'h78; bb[3] = 8'h56; bb[4] = 8'h34; bb[5] = 8'h12;
    bb[6] = 8'hEF; bb[7] = 8'hBE; bb[8] = 8'hAD; bb[9] = 8'hDE;
    send_buf(10);
    wait_idle("t1_timeout");
    check("t1_wn", 32'(wn), 32'd2);
    check("t1_a0", wa[0], 32'h0);
    check("t1_d0", wd[0], 32'h12345678);
    check("t1_a1", wa[1], 32'h4);
    check("t1_d1", wd[1], 32'hDEADBEEF);
    check("t1_done", 32'(done), 32'd1);
    check("t1_core", 32'(core_resetn), 32'd1);
    check("t1_ferr", 32'(frame_err), 32'd0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    check("t1_done_lat", 32'(done_rise - last_we), 32'd1);
`endif

    // empty image
    w0 = wn;
    pulse_start();
    check("t2_arm_done", 32'(done), 32'd0);
    bb[0] = 8'h00; bb[1] = 8'h00;
    send_buf(2);
    wait_idle("t2_timeout");
    check("t2_wn", 32'(wn - w0), 32'd0);
    check("t2_done", 32'(done), 32'd1);
    check("t2_core", 32'(core_resetn), 32'd1);

    // largest image that fits: 16 words
    w0 = wn;
    pulse_start();
    bb[0] = 8'h10; bb[1] = 8'h00;
    for (int i = 0; i < 64; i++) bb[i + 2] = 8'(i);
    send_buf(66);
    wait_idle("t3_timeout");
    check("t3_wn", 32'(wn - w0), 32'd16);
    check("t3_a15", wa[w0 + 15], 32'h3C);
    check("t3_d15", wd[w0 + 15], 32'h3F3E3D3C);
    check("t3_d0", wd[w0], 32'h03020100);
    check("t3_done", 32'(done), 32'd1);
`ifndef IMEM_LOADER_CHECKSUM_EN
    check("t3_done_lat", 32'(done_rise - last_we), 32'd1);
`endif

    // 17 words exceeds 2^AW
    w0 = wn;
    pulse_start();
    send_byte(8'h11, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_idle("t4_timeout");
    check("t4_ferr", 32'(frame_err), 32'd1);
    check("t4_core", 32'(core_resetn), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    check("t4_wn", 32'(wn - w0), 32'd0);

    // stop bit low on third payload byte
    w0 = wn;
    pulse_start();
    check("t5_ferr_clr0", 32'(frame_err), 32'd0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b0);
    repeat (4 * CPB) @(negedge clk);
    wait_idle("t5_timeout");
    check("t5_ferr", 32'(frame_err), 32'd1);
    check("t5_core", 32'(core_resetn), 32'd0);
    check("t5_wn", 32'(wn - w0), 32'd0);
    pulse_start();
    check("t5_ferr_clr", 32'(frame_err), 32'd0);
    bb[0] = 8'h01; bb[1] = 8'h00;
    bb[2] = 8'h11; bb[3] = 8'h22; bb[4] = 8'h33; bb[5] = 8'h44;
    send_buf(6);
    wait_idle("t5b_timeout");
    check("t5b_wn", 32'(wn - w0), 32'd1);
    check("t5b_a", wa[w0], 32'h0);
    check("t5b_d", wd[w0], 32'h44332211);
    check("t5b_done", 32'(done), 32'd1);

    // short low glitch while waiting for LEN_LO
    w0 = wn;
    pulse_start();
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (5 * CPB) @(negedge clk);
    check("t6_still_load", 32'(loading), 32'd1);
    bb[0] = 8'h01; bb[1] = 8'h00;
    bb[2] = 8'h01; bb[3] = 8'h02; bb[4] = 8'h03; bb[5] = 8'h04;
    send_buf(6);
    wait_idle("t6_timeout");
    check("t6_wn", 32'(wn - w0), 32'd1);
    check("t6_d", wd[w0], 32'h04030201);
    check("t6_done", 32'(done), 32'd1);
    check("t6_ferr", 32'(frame_err), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
    send_byte(8'h04, 1'b1);
    wait_idle("c1_timeout");
    check("c1_done", 32'(done), 32'd1);
    check("c1_cerr", 32'(chk_err), 32'd0);
    pulse_start();
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
    send_byte(8'h05, 1'b1);
    wait_idle("c2_timeout");
    check("c2_done", 32'(done), 32'd0);
    check("c2_cerr", 32'(chk_err), 32'd1);
    check("c2_core", 32'(core_resetn), 32'd0);
`endif

    // reset in the middle of a load
    pulse_start();
    send_byte(8'h01, 1'b1);
    resetn = 1'b0;
    @(negedge clk);
    check("mid_rst_core", 32'(core_resetn), 32'd0);
    check("mid_rst_load", 32'(loading), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("mid_rst_up", 32'(core_resetn), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
